// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: mic clock generation, DDR sampling of one or two mics on a shared
// data line, box-filter decimation with gain and saturation, single-entry valid/ready output.
module pdm_mic_decimator #(
   parameter int unsigned CLK_DIV   = 32,
   parameter int unsigned DECIM     = 256,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned CHANNELS  = 2
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            enable_in,
   input  logic [1:0]                      gain_in,
   input  logic                            mic_data_in,
   output logic                            mic_clk_out,
   output logic [CHANNELS*OUT_WIDTH-1:0]   sample_out,
   output logic                            valid_out,
   input  logic                            ready_in,
   output logic                            overflow_out
);

   localparam int unsigned CNT_W      = $clog2(CLK_DIV);
   localparam int unsigned HALF       = CLK_DIV / 2;
   localparam int unsigned LOG2_DECIM = $clog2(DECIM);
   localparam int unsigned TALLY_W    = $clog2(DECIM + 1);
   localparam int unsigned SHIFT      = LOG2_DECIM - OUT_WIDTH;
   // Centred tally needs TALLY_W+1 signed bits, gain adds 3 more; one spare bit of headroom.
   localparam int unsigned CONV_W     = TALLY_W + 5;
   localparam int unsigned SAMPLE_W   = CHANNELS * OUT_WIDTH;

   localparam logic signed [CONV_W-1:0] SAT_HI = CONV_W'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [CONV_W-1:0] SAT_LO = ~SAT_HI;

   logic [CNT_W-1:0]      cnt;
   logic [LOG2_DECIM-1:0] pcnt;
   logic [TALLY_W-1:0]    tally     [CHANNELS];
   logic [TALLY_W-1:0]    tally_fin [CHANNELS];
   logic [CHANNELS-1:0]   hit;
   logic                  half_hit;
   logic                  win_end;
   logic [SAMPLE_W-1:0]   new_sample;

   // Centre, scale and saturate one channel tally.
   function automatic logic [OUT_WIDTH-1:0] convert(input logic [TALLY_W-1:0] t,
                                                    input logic [1:0]         g);
      logic signed [CONV_W-1:0] v;
      v = $signed(CONV_W'(t)) - $signed(CONV_W'(DECIM / 2));
      v = (v <<< g) >>> SHIFT;
      if (v > SAT_HI)
         return SAT_HI[OUT_WIDTH-1:0];
      else if (v < SAT_LO)
         return SAT_LO[OUT_WIDTH-1:0];
      else
         return v[OUT_WIDTH-1:0];
   endfunction

   // Sampling strobes and the tally values including this cycle's bit.
   always_comb begin
      half_hit   = enable_in && (cnt == CNT_W'(HALF));
      win_end    = half_hit && (pcnt == LOG2_DECIM'(DECIM - 1));
      hit        = '0;
      new_sample = '0;
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
         hit[ch]       = enable_in && (cnt == ((ch == 0) ? CNT_W'(0) : CNT_W'(HALF)));
         tally_fin[ch] = tally[ch] + TALLY_W'(hit[ch] && mic_data_in);
         new_sample[ch*OUT_WIDTH +: OUT_WIDTH] = convert(tally_fin[ch], gain_in);
      end
   end

   // Clock divider, period counter and tallies; disable behaves like reset.
   always_ff @(posedge clk_in) begin
      if (rst_in || !enable_in) begin
         cnt  <= '0;
         pcnt <= '0;
         for (int ch = 0; ch < int'(CHANNELS); ch++)
            tally[ch] <= '0;
      end else begin
         cnt <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
         if (half_hit)
            pcnt <= win_end ? '0 : pcnt + LOG2_DECIM'(1);
         for (int ch = 0; ch < int'(CHANNELS); ch++)
            tally[ch] <= win_end ? '0 : tally_fin[ch];
      end
   end

   // Mic clock and the single-entry output register with sticky overflow.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mic_clk_out  <= 1'b0;
         sample_out   <= '0;
         valid_out    <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         mic_clk_out <= enable_in && (cnt < CNT_W'(HALF));
         if (win_end && (!valid_out || ready_in)) begin
            sample_out <= new_sample;
            valid_out  <= 1'b1;
         end else begin
            if (win_end)
               overflow_out <= 1'b1;
            if (ready_in)
               valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Scoreboard bench for pdm_mic_decimator: stereo DUT plus a mono build fed from the same pins.
module tb_pdm_mic_decimator;

   localparam int CLK_DIV = 8;
   localparam int DECIM   = 256;
   localparam int OW      = 8;
   localparam int LAT     = (DECIM - 1) * CLK_DIV + CLK_DIV / 2 + 1;
   localparam int PERIOD  = DECIM * CLK_DIV;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          enable_in;
   logic [1:0]    gain_in;
   logic          mic_data_in;
   logic          ready_in;
   logic          mic_clk_out;
   logic [2*OW-1:0] sample_out;
   logic          valid_out;
   logic          overflow_out;
   logic          m_clk;
   logic [OW-1:0] m_sample;
   logic          m_valid;
   logic          m_ovf;

   int errors = 0;
   int checks = 0;
   int k = 0;
   int dd0 = 0;
   int dd1 = 0;
   int q0[$];
   int q1[$];
   int qm[$];

   always #5 clk_in = ~clk_in;

   pdm_mic_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .OUT_WIDTH(OW), .CHANNELS(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .gain_in(gain_in),
      .mic_data_in(mic_data_in), .mic_clk_out(mic_clk_out), .sample_out(sample_out),
      .valid_out(valid_out), .ready_in(ready_in), .overflow_out(overflow_out));

   pdm_mic_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .OUT_WIDTH(OW), .CHANNELS(1)) dut_mono (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .gain_in(gain_in),
      .mic_data_in(mic_data_in), .mic_clk_out(m_clk), .sample_out(m_sample),
      .valid_out(m_valid), .ready_in(ready_in), .overflow_out(m_ovf));

   // Density d/256 pattern: any 256 consecutive mic periods carry exactly d ones.
   function automatic logic pbit(input int kk, input int d);
      return ((kk * d) & 255) < d;
   endfunction

   always @(negedge mic_clk_out) k <= k + 1;

   // ch0 data is presented while the mic clock is low, ch1 while it is high.
   always_comb mic_data_in = mic_clk_out ? pbit(k, dd1) : pbit(k, dd0);

   function automatic int s8(input logic [7:0] x);
      return int'($signed(x));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic expect_sample(input int e0, input int e1);
      q0.push_back(e0);
      q1.push_back(e1);
      qm.push_back(e0);
   endtask

   task automatic set_pattern(input int d0, input int d1, input int g);
      dd0     = d0;
      dd1     = d1;
      gain_in = 2'(g);
   endtask

   // Steps from cycle 0 until valid_out rises; checks mic clock phase and latency.
   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
         if (n == 1)
            chk({name, "_mclk_high"}, int'(mic_clk_out), 1);
         if (n == CLK_DIV / 2 + 1)
            chk({name, "_mclk_low"}, int'(mic_clk_out), 0);
      end while (!valid_out && n < LAT + 100);
      chk({name, "_latency"}, n, LAT);
   endtask

   task automatic run_vec(input string name, input int d0, input int d1, input int g,
                          input int e0, input int e1);
      set_pattern(d0, d1, g);
      expect_sample(e0, e1);
      ready_in  = 1'b1;
      enable_in = 1'b1;
      wait_valid(name);
      enable_in = 1'b0;
      step();
      step();
   endtask

   // Monitor: every transfer pops and compares against the scoreboard.
   always @(negedge clk_in) begin
      if (!rst_in && valid_out && ready_in) begin
         if (q0.size() == 0)
            chk("unexpected_stereo_sample", 1, 0);
         else begin
            chk("ch0", s8(sample_out[7:0]), q0.pop_front());
            chk("ch1", s8(sample_out[15:8]), q1.pop_front());
         end
      end
      if (!rst_in && m_valid && ready_in) begin
         if (qm.size() == 0)
            chk("unexpected_mono_sample", 1, 0);
         else
            chk("mono_ch0", s8(m_sample), qm.pop_front());
      end
   end

   initial begin
      int m;
      int seen;
      rst_in    = 1'b1;
      enable_in = 1'b0;
      ready_in  = 1'b0;
      gain_in   = 2'd0;
      repeat (3) step();
      chk("rst_sample", int'(sample_out), 0);
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_overflow", int'(overflow_out), 0);
      chk("rst_mclk", int'(mic_clk_out), 0);
      rst_in = 1'b0;
      step();

      // All ones, saturating; then the steady window period.
      set_pattern(256, 256, 0);
      expect_sample(127, 127);
      expect_sample(127, 127);
      ready_in  = 1'b1;
      enable_in = 1'b1;
      wait_valid("t1");
      m = 0;
      do begin
         step();
         m++;
      end while (!(valid_out && m > 1) && m < PERIOD + 100);
      chk("t1_period", m, PERIOD);
      enable_in = 1'b0;
      step();
      step();

      run_vec("t2_inv_clk", 256, 0,   0, 127, -128);
      run_vec("t3_d192_g0", 192, 192, 0, 64,  64);
      run_vec("t3_d192_g1", 192, 192, 1, 127, 127);
      run_vec("t3_d128",    128, 128, 0, 0,   0);
      run_vec("t3_d0",      0,   0,   0, -128, -128);
      run_vec("t3_g2_sat",  64,  192, 2, -128, 127);
      run_vec("t3_g3",      136, 120, 3, 64,  -64);

      // Two window ends without a consumer: first sample held, overflow set.
      ready_in = 1'b0;
      set_pattern(192, 192, 0);
      expect_sample(64, 64);
      enable_in = 1'b1;
      wait_valid("t4");
      chk("t4_first_ch0", s8(sample_out[7:0]), 64);
      set_pattern(0, 0, 0);
      repeat (PERIOD - 1) step();
      chk("t4_ovf_before", int'(overflow_out), 0);
      step();
      chk("t4_ovf_after", int'(overflow_out), 1);
      chk("t4_valid_held", int'(valid_out), 1);
      chk("t4_held_ch0", s8(sample_out[7:0]), 64);
      chk("t4_held_ch1", s8(sample_out[15:8]), 64);
      enable_in = 1'b0;
      ready_in  = 1'b1;
      step();
      chk("t4_valid_after_take", int'(valid_out), 0);
      chk("t4_ovf_sticky", int'(overflow_out), 1);

      // Disable mid-window: partial all-ones window must be discarded.
      set_pattern(256, 256, 0);
      enable_in = 1'b1;
      repeat (1002) step();
      chk("t5_mclk_running", int'(mic_clk_out), 1);
      chk("t5_no_early_valid", int'(valid_out), 0);
      enable_in = 1'b0;
      set_pattern(160, 96, 1);
      expect_sample(64, -64);
      step();
      chk("t5_mclk_stopped", int'(mic_clk_out), 0);
      seen = 0;
      repeat (9) begin
         step();
         seen |= int'(valid_out);
      end
      chk("t5_no_valid_while_off", seen, 0);
      enable_in = 1'b1;
      wait_valid("t5_reenable");
      enable_in = 1'b0;
      step();
      step();

      // Reset while a sample is pending and overflow is set.
      ready_in = 1'b0;
      set_pattern(256, 256, 0);
      enable_in = 1'b1;
      wait_valid("t6");
      chk("t6_pre_valid", int'(valid_out), 1);
      chk("t6_pre_ovf", int'(overflow_out), 1);
      rst_in = 1'b1;
      step();
      chk("t6_rst_sample", int'(sample_out), 0);
      chk("t6_rst_valid", int'(valid_out), 0);
      chk("t6_rst_ovf", int'(overflow_out), 0);
      chk("t6_rst_mclk", int'(mic_clk_out), 0);
      rst_in   = 1'b0;
      ready_in = 1'b1;
      expect_sample(127, 127);
      wait_valid("t6_after_reset");
      enable_in = 1'b0;
      repeat (3) step();

      chk("queue_drained", q0.size() + q1.size() + qm.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
